// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer that drives an external W-bit combinational
// word adder one word per cycle, LS word first, chaining the carry between words.
module multiword_add_sequencer #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*WORDS-1:0]   op_a,
    input  logic [W*WORDS-1:0]   op_b,
    input  logic                 op_sub,
    input  logic                 op_cin,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_cin,
    input  logic [W-1:0]         add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*WORDS-1:0]   result,
    output logic                 out_carry,
    output logic                 overflow
);
    localparam int N  = W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // out_valid, once raised, holds with a stable result until out_ready is seen.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            carry;
    logic            last;

    assign last    = (idx == IW'(WORDS - 1));
    assign add_a   = (state == RUN) ? a_q[idx*W +: W] : '0;
    assign add_b   = (state == RUN) ? b_q[idx*W +: W] : '0;
    assign add_cin = (state == RUN) ? carry : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            out_carry <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // B is stored pre-inverted so subtract is just add with cin=1.
                        a_q      <= op_a;
                        b_q      <= op_b ^ {N{op_sub}};
                        carry    <= op_sub | op_cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[idx*W +: W] <= add_sum;
                    carry              <= add_cout;
                    if (last) begin
                        out_carry <= add_cout;
                        overflow  <= (a_q[N-1] == b_q[N-1]) && (add_sum[W-1] != a_q[N-1]);
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: a WORDS=4 instance for directed/random/handshake
// scenarios and a WORDS=1 instance for the single-word corner, each with its own adder.
module tb_multiword_add_sequencer;
    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // WORDS=4 instance
    logic         in_valid = 1'b0, in_ready;
    logic [N-1:0] op_a = '0, op_b = '0;
    logic         op_sub = 1'b0, op_cin = 1'b0;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         out_valid, out_ready = 1'b0;
    logic [N-1:0] result;
    logic         out_carry, overflow;
    logic [N+1:0] exp_q[$];

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    multiword_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_carry(out_carry), .overflow(overflow)
    );

    // WORDS=1 instance
    logic         in_valid1 = 1'b0, in_ready1;
    logic [W-1:0] op_a1 = '0, op_b1 = '0;
    logic         op_sub1 = 1'b0, op_cin1 = 1'b0;
    logic [W-1:0] add_a1, add_b1, add_sum1;
    logic         add_cin1, add_cout1;
    logic         out_valid1, out_ready1 = 1'b0;
    logic [W-1:0] result1;
    logic         out_carry1, overflow1;
    logic [W+1:0] exp1_q[$];

    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {{W{1'b0}}, add_cin1};

    multiword_add_sequencer #(.W(W), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .op_sub(op_sub1), .op_cin(op_cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
        .out_carry(out_carry1), .overflow(overflow1)
    );

    // Reference: {result, carry, overflow} of the full-width add/subtract.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic sub, input logic cin);
        logic [N-1:0] beff;
        logic [N:0]   full;
        logic         ovf;
        beff = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, beff} + {{N{1'b0}}, (sub | cin)};
        ovf  = (a[N-1] == beff[N-1]) && (full[N-1] != a[N-1]);
        return {full[N-1:0], full[N], ovf};
    endfunction

    function automatic logic [W+1:0] model1(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub, input logic cin);
        logic [W-1:0] beff;
        logic [W:0]   full;
        logic         ovf;
        beff = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub | cin)};
        ovf  = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
        return {full[W-1:0], full[W], ovf};
    endfunction

    // Offers an operand pair, waits for acceptance, queues the expected result.
    // Returns one cycle after the accepting edge (the first RUN cycle).
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                        input logic cin, input logic [N+1:0] exp, output int waited);
        op_a = a; op_b = b; op_sub = sub; op_cin = cin; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 64) begin
            @(posedge clk); #1; waited++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for the result, optionally holds it off for 'hold' cycles, checks and accepts it.
    task automatic recv(input int hold, input bit check_lat);
        logic [N+1:0] exp;
        logic [N-1:0] held;
        int n;
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL out_valid_timeout: out_valid=0 after %0d cycles, required 1", n);
            return;
        end
        if (check_lat) begin
            checks++;
            if (n !== WORDS) begin
                failures++;
                $display("FAIL latency: %0d cycles after first RUN cycle, required %0d", n, WORDS);
            end
        end
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held) begin
                failures++;
                $display("FAIL backpressure_hold: out_valid=%0b in_ready=%0b result=%h, required 1 0 %h",
                         out_valid, in_ready, result, held);
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: result=%h with empty expected queue", result);
        end else begin
            exp = exp_q.pop_front();
            if ({result, out_carry, overflow} !== exp) begin
                failures++;
                $display("FAIL result: got result=%h carry=%0b ovf=%0b, required result=%h carry=%0b ovf=%0b",
                         result, out_carry, overflow, exp[N+1:2], exp[1], exp[0]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_handshake: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0 || out_carry !== 1'b0 ||
            overflow !== 1'b0 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b result=%h add_a=%h add_b=%h, required all 0",
                     in_ready, out_valid, result, add_a, add_b);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add_directed;
        int w;
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, {64'h0000_0000_0001_0000, 1'b0, 1'b0}, w);
        checks++;
        if (add_a !== 16'hFFFF || add_b !== 16'h0001 || add_cin !== 1'b0) begin
            failures++;
            $display("FAIL adder_drive_add: add_a=%h add_b=%h add_cin=%0b, required ffff 0001 0", add_a, add_b, add_cin);
        end
        recv(0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {64'h0, 1'b1, 1'b0}, w);
        recv(0, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {64'h8000_0000_0000_0000, 1'b0, 1'b1}, w);
        recv(0, 1'b1);
        send(64'h1234, 64'h1, 1'b0, 1'b1, {64'h1236, 1'b0, 1'b0}, w);
        recv(0, 1'b1);
    endtask

    task automatic test_sub_directed;
        int w;
        send(64'h5, 64'h7, 1'b1, 1'b0, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}, w);
        checks++;
        if (add_a !== 16'h0005 || add_b !== 16'hFFF8 || add_cin !== 1'b1) begin
            failures++;
            $display("FAIL adder_drive_sub: add_a=%h add_b=%h add_cin=%0b, required 0005 fff8 1", add_a, add_b, add_cin);
        end
        recv(0, 1'b1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}, w);
        recv(0, 1'b1);
        // op_cin must be ignored on subtract
        send(64'h9, 64'h9, 1'b1, 1'b1, {64'h0, 1'b1, 1'b0}, w);
        recv(0, 1'b1);
    endtask

    task automatic test_backpressure;
        int w;
        send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
             {64'h1234_5678_9ABC_DF00, 1'b0, 1'b0}, w);
        op_a = 64'h2; op_b = 64'h3; op_sub = 1'b0; op_cin = 1'b0; in_valid = 1'b1;
        recv(10, 1'b1);
        send(64'h2, 64'h3, 1'b0, 1'b0, {64'h5, 1'b0, 1'b0}, w);
        checks++;
        if (w !== 0) begin
            failures++;
            $display("FAIL second_accept: waited %0d cycles after handshake, required 0", w);
        end
        recv(0, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        int w;
        int seen;
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1, 66'h0, w);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        void'(exp_q.pop_back());
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0 || add_a !== '0 ||
            add_b !== '0 || add_cin !== 1'b0 || out_carry !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_run: in_ready=%0b out_valid=%0b result=%h add_a=%h, required all 0",
                     in_ready, out_valid, result, add_a);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < WORDS + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL discarded_op: out_valid seen %0d cycles, required 0", seen);
        end
        send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0,
             {64'h0000_0001_0000_0000, 1'b1, 1'b0}, w);
        recv(0, 1'b1);
    endtask

    task automatic test_back_to_back;
        int w;
        logic [N-1:0] a, b;
        logic sub, cin;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: a = {$urandom, $urandom};
                1: a = {N{1'b1}};
                2: a = {1'b0, {(N-1){1'b1}}};
                default: a = {1'b1, {(N-1){1'b0}}} | N'($urandom);
            endcase
            b   = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            send(a, b, sub, cin, model(a, b, sub, cin), w);
            if (i > 0) begin
                checks++;
                if (w !== 0) begin
                    failures++;
                    $display("FAIL back_to_back_accept: waited %0d cycles, required 0", w);
                end
            end
            recv((i % 4 == 3) ? int'($urandom_range(1, 3)) : 0, 1'b1);
        end
    endtask

    task automatic test_words1;
        int n;
        logic [W+1:0] exp;
        logic [W-1:0] a, b;
        logic sub, cin;
        for (int i = 0; i < 16; i++) begin
            a = W'($urandom); b = W'($urandom);
            if (i == 0) begin a = 16'h7FFF; b = 16'h0001; end
            if (i == 1) begin a = 16'hFFFF; b = 16'h0001; end
            sub = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            cin = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            op_a1 = a; op_b1 = b; op_sub1 = sub; op_cin1 = cin; in_valid1 = 1'b1;
            n = 0;
            while (!in_ready1 && n < 16) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            exp1_q.push_back(model1(a, b, sub, cin));
            n = 0;
            while (!out_valid1 && n < 16) begin @(posedge clk); #1; n++; end
            checks++;
            exp = exp1_q.pop_front();
            if (out_valid1 !== 1'b1 || n !== 1 || {result1, out_carry1, overflow1} !== exp) begin
                failures++;
                $display("FAIL words1: valid=%0b lat=%0d result=%h carry=%0b ovf=%0b, required 1 1 %h %0b %0b",
                         out_valid1, n, result1, out_carry1, overflow1, exp[W+1:2], exp[1], exp[0]);
            end
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_add_directed();
        test_sub_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_words1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
